// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: default widths, reset PC, instruction field
// positions and the fetch FSM state type.
package fetch_unit_pkg;

    localparam int unsigned                 DEF_PC_WIDTH    = 16;
    localparam int unsigned                 DEF_INSTR_WIDTH = 32;
    localparam logic [DEF_PC_WIDTH-1:0]     DEF_RESET_PC    = 16'h0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 9;
    localparam int unsigned RS_LSB     = 5;
    localparam int unsigned RD_MSB     = 4;
    localparam int unsigned RD_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } fetch_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [DEF_INSTR_WIDTH-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [RS_MSB-RS_LSB:0] rs_of(input logic [DEF_INSTR_WIDTH-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [RD_MSB-RD_LSB:0] rd_of(input logic [DEF_INSTR_WIDTH-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack, redirect input and decode valid/ready.
import fetch_unit_pkg::*;

interface fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   decode_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, decode_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, decode_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr}; entry 0 is always the registered head.
module fetch_queue #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [PC_WIDTH-1:0]    push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    output logic [1:0]             count_o,
    output logic                   head_valid_o,
    output logic [PC_WIDTH-1:0]    head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o
);

    logic [1:0]             count_q;
    logic [PC_WIDTH-1:0]    pc0_q, pc1_q;
    logic [INSTR_WIDTH-1:0] ins0_q, ins1_q;
    logic                   do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            pc0_q   <= '0;
            pc1_q   <= '0;
            ins0_q  <= '0;
            ins1_q  <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_q  <= push_pc_i;
                        ins0_q <= push_instr_i;
                    end else if (count_q == 2'd1) begin
                        pc1_q  <= push_pc_i;
                        ins1_q <= push_instr_i;
                    end
                    if (count_q != 2'd2) count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    pc0_q   <= pc1_q;
                    ins0_q  <= ins1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Single entry goes straight to the head; a full queue shifts.
                    if (count_q == 2'd1) begin
                        pc0_q  <= push_pc_i;
                        ins0_q <= push_instr_i;
                    end else begin
                        pc0_q  <= pc1_q;
                        ins0_q <= ins1_q;
                        pc1_q  <= push_pc_i;
                        ins1_q <= push_instr_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = pc0_q;
    assign head_instr_o = ins0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM with redirect
// handling, feeding a 2-entry queue toward decode.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int unsigned          PC_WIDTH    = DEF_PC_WIDTH,
    parameter int unsigned          INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = DEF_RESET_PC,
    parameter logic [PC_WIDTH-1:0]  PC_STEP     = PC_WIDTH'(1)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_e        state_q;
    logic                req_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;

    logic       push, pop, flush, issue_ok, head_valid;
    logic [1:0] q_count, count_d;

    assign pc_inc = pc_q + PC_STEP;

    // Issue decisions look at occupancy after this cycle's push/pop so an ack always has room.
    always_comb begin
        flush    = bus.redirect_valid;
        push     = (state_q == ST_BUSY) && bus.imem_ack && !flush;
        pop      = head_valid && bus.decode_ready && !flush;
        count_d  = flush ? 2'd0 : (q_count + 2'(push) - 2'(pop));
        issue_ok = (count_d <= 2'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= bus.redirect_pc;
                        addr_q  <= bus.redirect_pc;
                        req_q   <= 1'b1;
                        state_q <= ST_BUSY;
                    end else if (issue_ok) begin
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                        if (bus.imem_ack) addr_q  <= bus.redirect_pc;
                        else              state_q <= ST_DRAIN;
                    end else if (bus.imem_ack) begin
                        pc_q <= pc_inc;
                        if (issue_ok) begin
                            addr_q <= pc_inc;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // pc_q holds the pending redirect target; the old request keeps its address.
                    if (bus.redirect_valid) pc_q <= bus.redirect_pc;
                    if (bus.imem_ack) begin
                        addr_q  <= bus.redirect_valid ? bus.redirect_pc : pc_q;
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_queue (
        .clk          (clk),
        .rst          (reset),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .push_pc_i    (pc_q),
        .push_instr_i (bus.imem_rdata),
        .count_o      (q_count),
        .head_valid_o (head_valid),
        .head_pc_o    (bus.instr_pc),
        .head_instr_o (bus.instr)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = head_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, corner sequences and
// randomized traffic checked against an in-order instruction-stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (32),
        .RESET_PC    (16'h0000),
        .PC_STEP     (16'h0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int mem_mode = 0;   // 0: ack driven by caller, 1: fixed latency, 2: random
    int lat = 1;
    int cnt = 0;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mem_mode == 1) begin
            if (bus.imem_req && !reset) begin
                if (cnt >= lat - 1) begin bus.imem_ack = 1'b1; cnt = 0; end
                else begin bus.imem_ack = 1'b0; cnt++; end
            end else begin
                bus.imem_ack = 1'b0;
                cnt = 0;
            end
        end else if (mem_mode == 2) begin
            bus.imem_ack = bus.imem_req && ($urandom_range(0, 2) == 0);
        end
        bus.imem_rdata = word_of(bus.imem_addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.decode_ready = 1'b0;
        cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.imem_rdata = word_of(bus.imem_addr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        found;
        logic        seen_bad;
        logic [15:0] exp_pc;
        int          accepts;
        logic        p_req, p_ack, p_hold;
        logic [15:0] p_addr, p_ipc;
        logic [31:0] p_instr;

        bus.imem_rdata = '0;
        #1;
        // ---------------- reset values ----------------
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_ipc",   32'(bus.instr_pc), 32'd0);
        do_reset();

        // ---------------- directed cycle table ----------------
        tbl[0] = '{ack:1'b0, rdy:1'b1, req:1'b0, addr:16'h0, vld:1'b0, ipc:16'h0};
        tbl[1] = '{ack:1'b1, rdy:1'b1, req:1'b1, addr:16'h0, vld:1'b0, ipc:16'h0};
        tbl[2] = '{ack:1'b1, rdy:1'b1, req:1'b1, addr:16'h1, vld:1'b1, ipc:16'h0};
        tbl[3] = '{ack:1'b1, rdy:1'b1, req:1'b1, addr:16'h2, vld:1'b1, ipc:16'h1};
        tbl[4] = '{ack:1'b1, rdy:1'b0, req:1'b1, addr:16'h3, vld:1'b1, ipc:16'h2};
        tbl[5] = '{ack:1'b0, rdy:1'b0, req:1'b0, addr:16'h0, vld:1'b1, ipc:16'h2};
        tbl[6] = '{ack:1'b0, rdy:1'b1, req:1'b0, addr:16'h0, vld:1'b1, ipc:16'h2};
        tbl[7] = '{ack:1'b1, rdy:1'b1, req:1'b1, addr:16'h4, vld:1'b1, ipc:16'h3};
        tbl[8] = '{ack:1'b0, rdy:1'b1, req:1'b1, addr:16'h5, vld:1'b1, ipc:16'h4};
        tbl[9] = '{ack:1'b0, rdy:1'b0, req:1'b1, addr:16'h5, vld:1'b0, ipc:16'h0};
        mem_mode = 0;
        for (int r = 0; r < 10; r++) begin
            chk($sformatf("tbl%0d_req", r), 32'(bus.imem_req), 32'(tbl[r].req));
            if (tbl[r].req) chk($sformatf("tbl%0d_addr", r), 32'(bus.imem_addr), 32'(tbl[r].addr));
            chk($sformatf("tbl%0d_valid", r), 32'(bus.instr_valid), 32'(tbl[r].vld));
            if (tbl[r].vld) begin
                chk($sformatf("tbl%0d_ipc", r), 32'(bus.instr_pc), 32'(tbl[r].ipc));
                chk($sformatf("tbl%0d_instr", r), bus.instr, word_of(tbl[r].ipc));
            end
            bus.imem_ack = tbl[r].ack;
            bus.decode_ready = tbl[r].rdy;
            step();
        end

        // ---------------- 3-cycle memory latency ----------------
        do_reset();
        mem_mode = 1; lat = 3;
        bus.decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lat3_req_c%0d", i), 32'(bus.imem_req), 32'd1);
            chk($sformatf("lat3_addr_c%0d", i), 32'(bus.imem_addr), 32'h0);
            chk($sformatf("lat3_novalid_c%0d", i), 32'(bus.instr_valid), 32'd0);
        end
        chk("lat3_ack_on_third", 32'(bus.imem_ack), 32'd1);
        step();
        chk("lat3_valid", 32'(bus.instr_valid), 32'd1);
        chk("lat3_ipc", 32'(bus.instr_pc), 32'h0);
        chk("lat3_next_addr", 32'(bus.imem_addr), 32'h1);
        chk("lat3_next_req", 32'(bus.imem_req), 32'd1);

        // ---------------- redirect while BUSY, 2-cycle latency ----------------
        do_reset();
        mem_mode = 1; lat = 2;
        bus.decode_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.imem_req && bus.imem_addr == 16'h0005) found = 1'b1;
        end
        chk("rd40_reach_0005", 32'(found), 32'd1);
        chk("rd40_no_ack_yet", 32'(bus.imem_ack), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd40_drain_req", 32'(bus.imem_req), 32'd1);
        chk("rd40_drain_addr", 32'(bus.imem_addr), 32'h5);
        chk("rd40_flushed", 32'(bus.instr_valid), 32'd0);
        step();
        chk("rd40_new_addr", 32'(bus.imem_addr), 32'h40);
        chk("rd40_swallowed", 32'(bus.instr_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.instr_valid) found = 1'b1; else step();
        end
        chk("rd40_deliver", 32'(found), 32'd1);
        chk("rd40_first_ipc", 32'(bus.instr_pc), 32'h40);
        chk("rd40_first_instr", bus.instr, word_of(16'h0040));

        // ---------------- redirect coincident with ack ----------------
        do_reset();
        mem_mode = 1; lat = 1;
        bus.decode_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.imem_req && bus.imem_addr == 16'h0010) found = 1'b1;
        end
        chk("rdack_reach_0010", 32'(found && bus.imem_ack), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0020;
        step();
        bus.redirect_valid = 1'b0;
        chk("rdack_addr", 32'(bus.imem_addr), 32'h20);
        chk("rdack_req", 32'(bus.imem_req), 32'd1);
        chk("rdack_flushed", 32'(bus.instr_valid), 32'd0);
        seen_bad = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bus.imem_req && bus.imem_addr == 16'h0011) seen_bad = 1'b1;
            if (bus.instr_valid) found = 1'b1;
        end
        chk("rdack_deliver", 32'(found), 32'd1);
        chk("rdack_first_ipc", 32'(bus.instr_pc), 32'h20);
        chk("rdack_no_0011", 32'(seen_bad), 32'd0);

        // ---------------- async reset mid-request ----------------
        do_reset();
        mem_mode = 1; lat = 3;
        bus.decode_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.instr_valid && bus.imem_req) found = 1'b1;
        end
        chk("armid_setup", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("armid_req", 32'(bus.imem_req), 32'd0);
        chk("armid_valid", 32'(bus.instr_valid), 32'd0);
        chk("armid_ipc", 32'(bus.instr_pc), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        cnt = 0;
        step();
        chk("armid_resume_req", 32'(bus.imem_req), 32'd1);
        chk("armid_resume_addr", 32'(bus.imem_addr), 32'h0);

        // ---------------- PC wrap via redirect to 0xFFFF ----------------
        do_reset();
        mem_mode = 1; lat = 1;
        bus.decode_ready = 1'b1;
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr_ffff", 32'(bus.imem_addr), 32'hFFFF);
        step();
        chk("wrap_addr_0000", 32'(bus.imem_addr), 32'h0000);
        chk("wrap_ipc_ffff", 32'(bus.instr_pc), 32'hFFFF);
        step();
        chk("wrap_ipc_0000", 32'(bus.instr_pc), 32'h0000);
        chk("wrap_instr_0000", bus.instr, word_of(16'h0000));

        // ---------------- randomized traffic vs in-order stream model ----------------
        do_reset();
        mem_mode = 2;
        exp_pc = 16'h0000;
        accepts = 0;
        p_req = 1'b0; p_ack = 1'b0; p_hold = 1'b0;
        p_addr = '0; p_ipc = '0; p_instr = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (p_req && !p_ack) begin
                chk("rnd_req_held", 32'(bus.imem_req), 32'd1);
                chk("rnd_addr_stable", 32'(bus.imem_addr), 32'(p_addr));
            end
            if (p_hold) begin
                chk("rnd_head_valid_hold", 32'(bus.instr_valid), 32'd1);
                chk("rnd_head_pc_hold", 32'(bus.instr_pc), 32'(p_ipc));
                chk("rnd_head_instr_hold", bus.instr, p_instr);
            end
            bus.decode_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
            end else if (bus.instr_valid && bus.decode_ready) begin
                chk("rnd_ipc", 32'(bus.instr_pc), 32'(exp_pc));
                chk("rnd_instr", bus.instr, word_of(exp_pc));
                exp_pc = exp_pc + 16'd1;
                accepts++;
            end
            p_req   = bus.imem_req;
            p_ack   = bus.imem_ack;
            p_addr  = bus.imem_addr;
            p_hold  = bus.instr_valid && !bus.decode_ready && !bus.redirect_valid;
            p_ipc   = bus.instr_pc;
            p_instr = bus.instr;
        end
        chk("rnd_progress", 32'(accepts > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the Harvard 16-bit processor. It sits directly upstream of decode.
- Holds the program counter and issues word-addressed reads to the instruction memory over a req/ack handshake.
- Buffers returned 32-bit instructions in a 2-entry queue and presents them to decode with valid/ready.
- Supports a PC redirect from later stages (branch/jump); in-flight and queued work from the old path is discarded.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address
INSTR_WIDTH, 32, instruction word width
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 1, PC increment per instruction (memory is word-addressed)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request; held high until imem_ack
imem_addr  output  PC_WIDTH  read address; stable while imem_req high
imem_ack  input  1  request complete this cycle; imem_rdata valid
imem_rdata  input  INSTR_WIDTH  instruction word, sampled when imem_ack=1
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  PC_WIDTH  new fetch address
instr_valid  output  1  queue head valid toward decode
instr  output  INSTR_WIDTH  queue head instruction (feeds decode instr)
instr_pc  output  PC_WIDTH  address of queue head instruction
decode_ready  input  1  decode accepts head when instr_valid & decode_ready

Behaviour:
- Reset (async, immediate):
  - outputs: imem_req=0, instr_valid=0.
  - state: pc=RESET_PC, queue empty, state=IDLE.
  - imem_addr, instr and instr_pc are 0 during reset.
- Memory handshake:
  - At most one outstanding request.
  - imem_addr is pc of the request and stays constant from req rise to ack.
  - imem_ack is only meaningful while imem_req=1. An ack in the same cycle req rises is legal: 1-cycle latency.
- Issue rule: a request may start or continue back-to-back only if queue occupancy after this cycle's push/pop is at most 1. This guarantees every ack has a free slot; no data is ever dropped for lack of space.
- States:
  - IDLE: no request outstanding. Go to BUSY, with req=1 and addr=pc, when the issue rule allows.
  - BUSY: request outstanding.
    - On ack: push {pc, imem_rdata} and set pc=pc+PC_STEP.
    - Then stay in BUSY with the next address the following cycle if the issue rule allows; otherwise go to IDLE (req=0).
    - Throughput: 1 instruction/cycle when ack is immediate and decode is always ready.
  - DRAIN: request outstanding whose data must be discarded. req stays high with the old address. On ack, the data is dropped and the state goes to IDLE, or to BUSY at the saved redirect pc.
- Redirect (redirect_valid=1 at a clock edge; highest priority):
  - Flush queue: instr_valid=0 next cycle; any pop in this cycle is ignored.
  - pc=redirect_pc.
  - IDLE: next cycle goes BUSY at redirect_pc.
  - BUSY with no ack this cycle: go to DRAIN.
  - BUSY with ack this cycle: discard rdata and go to BUSY at redirect_pc. No increment from the killed fetch.
  - DRAIN: update the saved pc to the newest redirect_pc and stay in DRAIN.
- Queue: 2 entries, FIFO order.
  - Push and pop in the same cycle are allowed at any occupancy from 1 to 2.
  - Push to an empty queue is visible on instr_valid the next cycle; there is no combinational bypass.
  - instr and instr_pc are registered head values, stable while instr_valid=1 and decode_ready=0.
- PC arithmetic: modulo 2^PC_WIDTH. 16'hFFFF + 1 wraps to 16'h0000 with no flag.
- Reset mid-request: req drops asynchronously. The instruction memory shares reset and abandons the transaction.

Decomposition:
- Shared header cpu_defs.vh holds:
  - PC_WIDTH, INSTR_WIDTH, RESET_PC;
  - opcode field position [31:26];
  - register field positions [4:0] and [9:5].
  Decode uses the same header.
- One sub-module: fetch_queue, a 2-entry FIFO of {pc, instr} with push, pop, flush, count, head outputs and async reset.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset then release: ack immediate, decode_ready=1 → imem_addr sequence 0,1,2,3 on consecutive cycles; instr/instr_pc appear 1 cycle after each ack, one per cycle.
- Memory latency 3 cycles → imem_addr held at 0x0000 for 3 cycles with req=1; instr_valid rises the cycle after ack; next req at 0x0001.
- decode_ready=0 for 5 cycles, immediate ack → exactly 2 instructions queued (pc 0,1); req low thereafter; instr holds the pc=0 word; on ready=1, words are delivered in order 0,1,2 with no loss or duplication.
- Redirect to 0x0040 while BUSY at 0x0005 with 2-cycle latency:
  - pending ack is swallowed;
  - queue flushed;
  - next req addr 0x0040;
  - first delivered instr_pc=0x0040.
- Redirect coincident with ack at 0x0010 → rdata discarded; next addr 0x0020 (redirect_pc); pc never shows 0x0011.
- Reset asserted mid-request with queue full → same cycle, asynchronously: imem_req=0 and instr_valid=0; after release, fetch resumes at RESET_PC. Separately, redirect to 0xFFFF → next fetch 0x0000.
